// File: rtl/knn_seq_ctrl_pkg.sv
// Shared types and default sizes for the KNN sequencer, point memory and sorter.
// State encodings are 3-bit so they fit debug/status fields elsewhere.
package knn_seq_ctrl_pkg;

    localparam int KNN_N_MAX   = 64;
    localparam int KNN_IDX_W   = 6;
    localparam int KNN_COORD_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_ISSUE = 3'd4,
        S_DONE  = 3'd5
    } knn_state_e;

endpackage

// File: rtl/knn_seq_ctrl_if.sv
// Point-memory read port plus the valid/ready point stream into the distance/sort datapath.
interface knn_seq_ctrl_if
    import knn_seq_ctrl_pkg::*;
#(
    parameter int IDX_W   = KNN_IDX_W,
    parameter int COORD_W = KNN_COORD_W
);
    logic                   mem_en;
    logic [IDX_W-1:0]       mem_addr;
    logic [2*COORD_W-1:0]   mem_rdata;

    logic                   dp_clear;
    logic                   dp_valid;
    logic                   dp_ready;
    logic [COORD_W-1:0]     dp_x1;
    logic [COORD_W-1:0]     dp_y1;
    logic [COORD_W-1:0]     dp_x2;
    logic [COORD_W-1:0]     dp_y2;
    logic [IDX_W-1:0]       dp_idx;

    modport master (
        output mem_en, mem_addr,
        input  mem_rdata,
        output dp_clear, dp_valid, dp_x1, dp_y1, dp_x2, dp_y2, dp_idx,
        input  dp_ready
    );

    modport slave (
        input  mem_en, mem_addr,
        output mem_rdata,
        input  dp_clear, dp_valid, dp_x1, dp_y1, dp_x2, dp_y2, dp_idx,
        output dp_ready
    );
endinterface

// File: rtl/knn_seq_ctrl.sv
// KNN sequencer: latches a query point, clears the sorter, then streams the stored
// training points from a 1-cycle-latency memory into the datapath, one per transfer.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; latched registers hold last values
//   S_CLEAR | dp_clear pulse, empties the sorter neighbour list
//   S_FETCH | mem_en asserted, mem_addr = cnt
//   S_WAIT  | memory returns word; captured into dp_x2/dp_y2
//   S_ISSUE | dp_valid held until dp_ready; last point -> S_DONE
//   S_DONE  | done set, busy dropped; back to S_IDLE next edge
module knn_seq_ctrl
    import knn_seq_ctrl_pkg::*;
#(
    parameter int N_MAX   = KNN_N_MAX,
    parameter int IDX_W   = KNN_IDX_W,
    parameter int COORD_W = KNN_COORD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [IDX_W:0]        n_points,
    input  logic [2*COORD_W-1:0]  test_point,
    knn_seq_ctrl_if.master        bus,
    output logic                  busy,
    output logic                  done
);

    localparam logic [IDX_W:0] N_MAX_W = (IDX_W+1)'(N_MAX);
    localparam logic [IDX_W:0] ONE_N   = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] ONE_C = IDX_W'(1);

    knn_state_e           state;
    logic [IDX_W:0]       n_q;
    logic [IDX_W-1:0]     cnt;
    logic                 mem_en_q;
    logic                 dp_clear_q;
    logic                 dp_valid_q;
    logic [COORD_W-1:0]   x1_q, y1_q, x2_q, y2_q;
    logic                 busy_q, done_q;

    logic last_pt;
    assign last_pt = ({1'b0, cnt} == (n_q - ONE_N));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            n_q        <= '0;
            cnt        <= '0;
            mem_en_q   <= 1'b0;
            dp_clear_q <= 1'b0;
            dp_valid_q <= 1'b0;
            x1_q       <= '0;
            y1_q       <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (abort) begin
            // Abort beats a same-cycle start and leaves no completion flag behind.
            state      <= S_IDLE;
            mem_en_q   <= 1'b0;
            dp_clear_q <= 1'b0;
            dp_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x1_q       <= test_point[COORD_W-1:0];
                        y1_q       <= test_point[2*COORD_W-1:COORD_W];
                        n_q        <= (n_points > N_MAX_W) ? N_MAX_W : n_points;
                        cnt        <= '0;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        dp_clear_q <= 1'b1;
                        state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    dp_clear_q <= 1'b0;
                    if (n_q == '0) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        mem_en_q <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    mem_en_q <= 1'b0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    x2_q       <= bus.mem_rdata[COORD_W-1:0];
                    y2_q       <= bus.mem_rdata[2*COORD_W-1:COORD_W];
                    dp_valid_q <= 1'b1;
                    state      <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (bus.dp_ready) begin
                        dp_valid_q <= 1'b0;
                        if (last_pt) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            cnt      <= cnt + ONE_C;
                            mem_en_q <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // cnt only advances after a transfer, so it doubles as address and index.
    assign bus.mem_en   = mem_en_q;
    assign bus.mem_addr = cnt;
    assign bus.dp_clear = dp_clear_q;
    assign bus.dp_valid = dp_valid_q;
    assign bus.dp_x1    = x1_q;
    assign bus.dp_y1    = y1_q;
    assign bus.dp_x2    = x2_q;
    assign bus.dp_y2    = y2_q;
    assign bus.dp_idx   = cnt;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_knn_seq_ctrl.sv
// Directed bench for knn_seq_ctrl: point memory model, transfer log and hand-computed timing.
module tb_knn_seq_ctrl;

    localparam int IDX_W   = 6;
    localparam int COORD_W = 16;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic [IDX_W:0]       n_points;
    logic [2*COORD_W-1:0] test_point;
    logic                 busy;
    logic                 done;

    knn_seq_ctrl_if #(.IDX_W(IDX_W), .COORD_W(COORD_W)) bus ();

    knn_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .n_points   (n_points),
        .test_point (test_point),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Point memory: word i = {y,x} with x = 2i+1, y = 2i+2.
    logic [31:0] mem [64];
    initial bus.mem_rdata = '0;
    always @(posedge clk) if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          t0 = 0;
    int          rel_m;
    bit          armed = 0;
    int          xfer_cyc [$];
    int          xfer_idx [$];
    logic [31:0] xfer_pt  [$];
    int          n_clear, clear_cyc, done_cyc, last_addr, max_addr;
    bit          done_seen, busy1, busy2;

    always @(negedge clk) begin
        rel_m = cyc - t0;
        if (armed && rel_m >= 1) begin
            if (bus.dp_valid && bus.dp_ready) begin
                xfer_cyc.push_back(rel_m);
                xfer_idx.push_back(int'(bus.dp_idx));
                xfer_pt.push_back({bus.dp_y2, bus.dp_x2});
            end
            if (bus.dp_clear) begin
                n_clear++;
                clear_cyc = rel_m;
            end
            if (bus.mem_en) begin
                last_addr = int'(bus.mem_addr);
                if (last_addr > max_addr) max_addr = last_addr;
            end
            if (done && !done_seen) begin
                done_seen = 1;
                done_cyc  = rel_m;
            end
            if (rel_m == 1) busy1 = busy;
            if (rel_m == 2) busy2 = busy;
        end
    end

    task automatic launch(input int n, input logic [31:0] tp);
        @(posedge clk); #1;
        start      = 1'b1;
        n_points   = (IDX_W+1)'(n);
        test_point = tp;
        t0         = cyc;
        xfer_cyc.delete();
        xfer_idx.delete();
        xfer_pt.delete();
        n_clear   = 0;
        clear_cyc = -1;
        done_cyc  = -1;
        done_seen = 0;
        last_addr = -1;
        max_addr  = -1;
        busy1     = 0;
        busy2     = 0;
        armed     = 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic at_cycle(input int r);
        while ((cyc - t0) < r) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done_seen && k < 400) begin
            @(posedge clk);
            k++;
        end
        chk({tag, ".done_seen"}, done_seen, 1);
    endtask

    task automatic check_xfers(input string tag, input int n, input int first);
        chk({tag, ".n_xfer"}, xfer_idx.size(), n);
        for (int k = 0; k < n && k < xfer_idx.size(); k++) begin
            chk($sformatf("%s.idx%0d", tag, k), xfer_idx[k], k);
            chk($sformatf("%s.cyc%0d", tag, k), xfer_cyc[k], first + 3*k);
            chk($sformatf("%s.pt%0d", tag, k), xfer_pt[k], {16'(2*k+2), 16'(2*k+1)});
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, ".mem_en"},   bus.mem_en, 0);
        chk({tag, ".mem_addr"}, bus.mem_addr, 0);
        chk({tag, ".dp_clear"}, bus.dp_clear, 0);
        chk({tag, ".dp_valid"}, bus.dp_valid, 0);
        chk({tag, ".dp_x1"},    bus.dp_x1, 0);
        chk({tag, ".dp_y1"},    bus.dp_y1, 0);
        chk({tag, ".dp_x2"},    bus.dp_x2, 0);
        chk({tag, ".dp_y2"},    bus.dp_y2, 0);
        chk({tag, ".dp_idx"},   bus.dp_idx, 0);
        chk({tag, ".busy"},     busy, 0);
        chk({tag, ".done"},     done, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {16'(2*i+2), 16'(2*i+1)};
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        n_points = '0; test_point = '0; bus.dp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_zero("reset");

        // n=3, ready tied high
        launch(3, {16'd200, 16'd100});
        wait_done("n3");
        check_xfers("n3", 3, 4);
        chk("n3.n_clear", n_clear, 1);
        chk("n3.clear_cyc", clear_cyc, 1);
        chk("n3.done_cyc", done_cyc, 11);
        chk("n3.busy1", busy1, 1);
        chk("n3.dp_x1", bus.dp_x1, 100);
        chk("n3.dp_y1", bus.dp_y1, 200);
        @(negedge clk);
        chk("n3.busy_after", busy, 0);
        chk("n3.done_sticky", done, 1);

        // n=0: clear only
        launch(0, {16'd7, 16'd8});
        wait_done("n0");
        chk("n0.n_clear", n_clear, 1);
        chk("n0.n_xfer", xfer_idx.size(), 0);
        chk("n0.done_cyc", done_cyc, 2);
        chk("n0.busy1", busy1, 1);
        chk("n0.busy2", busy2, 0);

        // n=2 with dp_ready low for 5 ISSUE cycles on idx0
        bus.dp_ready = 1'b0;
        launch(2, {16'd3, 16'd4});
        at_cycle(8);
        @(negedge clk);
        chk("stall.valid", bus.dp_valid, 1);
        chk("stall.idx", bus.dp_idx, 0);
        chk("stall.x2", bus.dp_x2, 1);
        chk("stall.y2", bus.dp_y2, 2);
        at_cycle(9);
        bus.dp_ready = 1'b1;
        wait_done("stall");
        check_xfers("stall", 2, 9);
        chk("stall.done_cyc", done_cyc, 13);

        // clamp: n=64 and n=100 behave identically
        launch(64, 32'h0);
        wait_done("n64");
        check_xfers("n64", 64, 4);
        chk("n64.done_cyc", done_cyc, 194);
        chk("n64.last_addr", last_addr, 63);
        chk("n64.max_addr", max_addr, 63);
        launch(100, 32'h0);
        wait_done("n100");
        check_xfers("n100", 64, 4);
        chk("n100.done_cyc", done_cyc, 194);
        chk("n100.last_addr", last_addr, 63);
        chk("n100.max_addr", max_addr, 63);

        // abort in ISSUE of idx1, then restart with n=1
        launch(4, 32'h0);
        at_cycle(7);
        abort = 1'b1;
        at_cycle(8);
        abort = 1'b0;
        @(negedge clk);
        chk("abort.busy", busy, 0);
        chk("abort.valid", bus.dp_valid, 0);
        chk("abort.mem_en", bus.mem_en, 0);
        chk("abort.done", done, 0);
        at_cycle(20);
        chk("abort.n_xfer", xfer_idx.size(), 2);
        chk("abort.done_seen", done_seen, 0);
        launch(1, 32'h0);
        wait_done("restart");
        check_xfers("restart", 1, 4);
        chk("restart.done_cyc", done_cyc, 5);

        // start pulsed while busy is ignored
        launch(3, {16'd50, 16'd40});
        at_cycle(5);
        start = 1'b1; n_points = 7'd1; test_point = {16'd9, 16'd9};
        at_cycle(6);
        start = 1'b0;
        wait_done("busy_start");
        check_xfers("busy_start", 3, 4);
        chk("busy_start.done_cyc", done_cyc, 11);
        chk("busy_start.dp_x1", bus.dp_x1, 40);
        chk("busy_start.dp_y1", bus.dp_y1, 50);

        // start and abort together in IDLE: abort wins
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; n_points = 7'd2;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort.busy", busy, 0);
        chk("start_abort.clear", bus.dp_clear, 0);
        chk("start_abort.done", done, 0);

        // rst during ISSUE of idx2
        launch(3, {16'd11, 16'd12});
        at_cycle(10);
        rst = 1'b1;
        at_cycle(11);
        @(negedge clk);
        check_idle_zero("rst_mid");
        at_cycle(12);
        rst = 1'b0;
        at_cycle(18);
        @(negedge clk);
        chk("rst_mid.done_later", done, 0);
        chk("rst_mid.busy_later", busy, 0);
        chk("rst_mid.done_seen", done_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
